// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM.
// Sequences fetch/decode/execute/memory/writeback for R-type, lw, sw, beq, bne, j and addi,
// drives the ALU select and operand muxes, handshakes with a shared memory and counts
// retired instructions.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   opcode_i, funct_i          IR fields, sampled in DECODE only
//   zero_flag_i                ALU equality flag
//   mem_ready_i                memory completes the current request this cycle
//   alu_sel_o                  ALU op (000 AND, 001 ADD, 010 OR, 011 SUB, 100 SLT, 101 NOR)
//   alu_src_a_o, alu_src_b_o   ALU operand muxes
//   pc_source_o, pc_write_o    PC mux and qualified load enable
//   iord_o, mem_req_o, mem_write_o  memory address select / request / write
//   ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o  datapath enables and muxes
//   illegal_op_o, bus_error_o  one-cycle exception pulses
//   halted_o                   high while in HALT
//   instr_count_o              retired instruction count
//   state_o                    current state encoding
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    input  logic        zero_flag_i,
    input  logic        mem_ready_i,
    output logic [2:0]  alu_sel_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  pc_source_o,
    output logic        pc_write_o,
    output logic        iord_o,
    output logic        mem_req_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        reg_write_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        illegal_op_o,
    output logic        bus_error_o,
    output logic        halted_o,
    output logic [31:0] instr_count_o,
    output logic [3:0]  state_o
);

    localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StRExec    = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiEx   = 4'd10,
        StAddiWb   = 4'd11,
        StHalt     = 4'd12
    } state_e;

    // Moore outputs; pc_write here is only the unconditional (jump) part.
    typedef struct packed {
        logic [2:0] alu_sel;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       iord;
        logic       mem_req;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       halted;
    } ctrl_t;

    function automatic ctrl_t ctrl_of(state_e s, logic [2:0] rop);
        ctrl_t c;
        c         = '0;
        c.alu_sel = 3'b001;
        case (s)
            StFetch:    begin c.mem_req = 1'b1; c.src_b = 2'b01; end
            StDecode:   c.src_b = 2'b11;
            StMemAddr:  begin c.src_a = 1'b1; c.src_b = 2'b10; end
            StMemRead:  begin c.mem_req = 1'b1; c.iord = 1'b1; end
            StMemWb:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            StMemWrite: begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.iord = 1'b1; end
            StRExec:    begin c.src_a = 1'b1; c.alu_sel = rop; end
            StRWb:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            StBranch:   begin c.src_a = 1'b1; c.alu_sel = 3'b011; c.pc_src = 2'b01; end
            StJump:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
            StAddiEx:   begin c.src_a = 1'b1; c.src_b = 2'b10; end
            StAddiWb:   c.reg_write = 1'b1;
            StHalt:     c.halted = 1'b1;
            default:    ;
        endcase
        return c;
    endfunction

    state_e           state_q, state_d;
    ctrl_t            ctrl_q;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [31:0]      count_q;
    logic             bne_q, bne_d;
    logic             store_q, store_d;   // lw/sw differ only in opcode bit 3
    logic [2:0]       rop_q, rop_d;
    logic [2:0]       funct_rop;
    logic             funct_ok;
    logic             illegal;
    logic             timeout;
    logic             retire;
    logic             entering_mem;

    always_comb begin
        funct_ok  = 1'b1;
        funct_rop = 3'b001;
        case (funct_i)
            6'h20:   funct_rop = 3'b001;
            6'h22:   funct_rop = 3'b011;
            6'h24:   funct_rop = 3'b000;
            6'h25:   funct_rop = 3'b010;
            6'h2A:   funct_rop = 3'b100;
            6'h27:   funct_rop = 3'b101;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        bne_d   = bne_q;
        store_d = store_q;
        rop_d   = rop_q;
        illegal = 1'b0;
        timeout = 1'b0;
        retire  = 1'b0;
        case (state_q)
            StFetch: if (mem_ready_i) state_d = StDecode;
            StDecode: begin
                bne_d   = opcode_i[0];
                store_d = opcode_i[3];
                rop_d   = funct_rop;
                case (opcode_i)
                    6'h23, 6'h2B: state_d = StMemAddr;
                    6'h00:        if (funct_ok) state_d = StRExec; else illegal = 1'b1;
                    6'h04, 6'h05: state_d = StBranch;
                    6'h02:        state_d = StJump;
                    6'h08:        state_d = StAddiEx;
                    default:      illegal = 1'b1;
                endcase
                if (illegal) state_d = StFetch;
            end
            StMemAddr:  state_d = store_q ? StMemWrite : StMemRead;
            StMemRead:  if (mem_ready_i) state_d = StMemWb;
            StMemWb:    begin state_d = StFetch; retire = 1'b1; end
            StMemWrite: if (mem_ready_i) begin state_d = StFetch; retire = 1'b1; end
            StRExec:    state_d = StRWb;
            StRWb:      begin state_d = StFetch; retire = 1'b1; end
            StBranch:   begin state_d = StFetch; retire = 1'b1; end
            StJump:     begin state_d = StFetch; retire = 1'b1; end
            StAddiEx:   state_d = StAddiWb;
            StAddiWb:   begin state_d = StFetch; retire = 1'b1; end
            StHalt:     state_d = StHalt;
            default:    state_d = StFetch;
        endcase

        // A ready on the last allowed cycle still completes normally.
        if (ctrl_q.mem_req && !mem_ready_i && (wait_q == WaitLast)) begin
            timeout = 1'b1;
            state_d = StHalt;
        end

        entering_mem = (state_d != state_q) &&
                       (state_d == StFetch || state_d == StMemRead || state_d == StMemWrite);
        if (mem_ready_i || entering_mem) begin
            wait_d = '0;
        end else if (ctrl_q.mem_req) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            ctrl_q  <= ctrl_of(StFetch, 3'b000);
            wait_q  <= '0;
            count_q <= 32'd0;
            bne_q   <= 1'b0;
            store_q <= 1'b0;
            rop_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_of(state_d, rop_d);
            wait_q  <= wait_d;
            bne_q   <= bne_d;
            store_q <= store_d;
            rop_q   <= rop_d;
            if (retire) count_q <= count_q + 32'd1;
        end
    end

    assign alu_sel_o     = ctrl_q.alu_sel;
    assign alu_src_a_o   = ctrl_q.src_a;
    assign alu_src_b_o   = ctrl_q.src_b;
    assign pc_source_o   = ctrl_q.pc_src;
    assign pc_write_o    = ctrl_q.pc_write
                         | ((state_q == StFetch) & mem_ready_i)
                         | ((state_q == StBranch) & (zero_flag_i ^ bne_q));
    assign iord_o        = ctrl_q.iord;
    assign mem_req_o     = ctrl_q.mem_req;
    assign mem_write_o   = ctrl_q.mem_write;
    assign ir_write_o    = (state_q == StFetch) & mem_ready_i;
    assign reg_write_o   = ctrl_q.reg_write;
    assign reg_dst_o     = ctrl_q.reg_dst;
    assign mem_to_reg_o  = ctrl_q.mem_to_reg;
    assign illegal_op_o  = illegal;
    assign bus_error_o   = timeout;
    assign halted_o      = ctrl_q.halted;
    assign instr_count_o = count_q;
    assign state_o       = state_q;

endmodule
